// File: rtl/count_ascii_tx.sv
// Latches a counter value, converts it to BCD by double-dabble and pushes it
// to the TX FIFO as four ASCII digits, optionally followed by CR LF.
module count_ascii_tx #(
  parameter int COUNT_W = 14,
  parameter int MAX_VAL = 9999,
  parameter bit EOL_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COUNT_W-1:0] i_count,
  input  logic               i_send,
  input  logic               i_fifo_full,
  output logic               o_push,
  output logic [7:0]         o_data,
  output logic               o_busy,
  output logic               o_done
);

  localparam int                 CNT_W    = $clog2(COUNT_W + 1);
  localparam logic [COUNT_W-1:0] MAX_C    = COUNT_W'(MAX_VAL);
  localparam logic [2:0]         LAST_IDX = EOL_EN ? 3'd5 : 3'd3;

  typedef enum logic [1:0] {IDLE, CONV, SEND, DONE} state_e;

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   bin_q, bin_d;
  logic [15:0]          bcd_q, bcd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [15:0]          bcd_adj;
  logic [16+COUNT_W-1:0] shifted;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Double-dabble step: correct every nibble >= 5, then shift one bit in.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin_q} << 1;
  end

  assign o_push = (state_q == SEND) && !i_fifo_full;
  assign o_busy = (state_q != IDLE);
  assign o_done = (state_q == DONE);

  always_comb begin
    o_data = 8'h00;
    if (state_q == SEND) begin
      case (idx_q)
        3'd0:    o_data = {4'h3, bcd_q[15:12]};
        3'd1:    o_data = {4'h3, bcd_q[11:8]};
        3'd2:    o_data = {4'h3, bcd_q[7:4]};
        3'd3:    o_data = {4'h3, bcd_q[3:0]};
        3'd4:    o_data = 8'h0D;
        3'd5:    o_data = 8'h0A;
        default: o_data = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (i_send) begin
          bin_d   = (i_count > MAX_C) ? MAX_C : i_count;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d = shifted[16+COUNT_W-1:COUNT_W];
        bin_d = shifted[COUNT_W-1:0];
        if (cnt_q == CNT_W'(COUNT_W - 1)) begin
          idx_d   = '0;
          state_d = SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SEND: begin
        // Index only moves on a cycle the FIFO actually takes the byte.
        if (o_push) begin
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_count_ascii_tx.sv
// Scoreboard bench for count_ascii_tx: one instance with CR LF, one without.
module tb_count_ascii_tx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] cnt_in = '0;
  logic        send_a = 1'b0, send_b = 1'b0;
  logic        full_a = 1'b0, full_b = 1'b0;
  logic        push_a, push_b, busy_a, busy_b, dn_a, dn_b;
  logic [7:0]  data_a, data_b;

  always #5 clk = ~clk;

  count_ascii_tx #(.COUNT_W(14), .MAX_VAL(9999), .EOL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .i_count(cnt_in), .i_send(send_a), .i_fifo_full(full_a),
    .o_push(push_a), .o_data(data_a), .o_busy(busy_a), .o_done(dn_a));

  count_ascii_tx #(.COUNT_W(14), .MAX_VAL(9999), .EOL_EN(1'b0)) dut4 (
    .clk(clk), .rst(rst), .i_count(cnt_in), .i_send(send_b), .i_fifo_full(full_b),
    .o_push(push_b), .o_data(data_b), .o_busy(busy_b), .o_done(dn_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  int done_a = 0, done_b = 0, sent_a = 0, sent_b = 0;
  int mode = 0, slo = 0, shi = -1;
  logic [7:0] qa[$], qb[$];
  logic [7:0] ea, eb;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: clamp, split into decimal digits, ASCII-encode.
  task automatic model(input int v, input bit b);
    int c;
    logic [7:0] by[$];
    c = (v > 9999) ? 9999 : v;
    by.push_back(8'(48 + c / 1000));
    by.push_back(8'(48 + (c / 100) % 10));
    by.push_back(8'(48 + (c / 10) % 10));
    by.push_back(8'(48 + c % 10));
    if (!b) begin by.push_back(8'd13); by.push_back(8'd10); end
    foreach (by[i]) if (b) qb.push_back(by[i]); else qa.push_back(by[i]);
  endtask

  // FIFO full driver: 0 = never, 1 = random, 2 = toggle, 3 = window [slo,shi].
  initial forever begin
    @(posedge clk); #1;
    case (mode)
      1:       full_a = 1'($urandom_range(0, 1));
      2:       full_a = ~full_a;
      3:       full_a = (cyc >= slo) && (cyc <= shi);
      default: full_a = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (push_a === 1'b1) begin
      if (qa.size() == 0) chk("a_unexpected_push", 0, 1);
      else begin ea = qa.pop_front(); chk("a_byte", int'(data_a), int'(ea)); end
    end
    if (dn_a === 1'b1) begin chk("a_done_after_last_byte", qa.size(), 0); done_a++; end
  end

  always @(negedge clk) begin
    if (push_b === 1'b1) begin
      if (qb.size() == 0) chk("b_unexpected_push", 0, 1);
      else begin eb = qb.pop_front(); chk("b_byte", int'(data_b), int'(eb)); end
    end
    if (dn_b === 1'b1) begin chk("b_done_after_last_byte", qb.size(), 0); done_b++; end
  end

  // Called just after a posedge; returns the cycle number of the accepting edge.
  task automatic send(input int v, input bit b, output int a);
    cnt_in = 14'(v);
    if (b) begin send_b = 1'b1; sent_b++; end
    else   begin send_a = 1'b1; sent_a++; end
    a = cyc + 1;
    model(v, b);
    @(posedge clk); #1;
    send_a = 1'b0;
    send_b = 1'b0;
    cnt_in = 14'($urandom_range(0, 16383));
  endtask

  task automatic wait_done(input bit b, output int dc);
    int n = 0;
    while (n < 400) begin
      @(negedge clk);
      if ((b ? dn_b : dn_a) === 1'b1) break;
      n++;
    end
    if (n >= 400) chk("done_timeout", 0, 1);
    dc = cyc;
    @(posedge clk); #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  int a, dc;
  int vals[3] = '{0, 9999, 16383};

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_push", int'(push_a), 0);
    chk("reset_data", int'(data_a), 0);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_done", int'(dn_a), 0);
    chk("reset_busy_b", int'(busy_b), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1234, exact cycle-by-cycle timing
    send(1234, 1'b0, a);
    for (int k = 0; k <= 21; k++) begin
      @(negedge clk);
      chk($sformatf("t1_push_k%0d", k), int'(push_a), (k >= 14 && k <= 19) ? 1 : 0);
      chk($sformatf("t1_busy_k%0d", k), int'(busy_a), (k <= 20) ? 1 : 0);
      chk($sformatf("t1_done_k%0d", k), int'(dn_a), (k == 20) ? 1 : 0);
    end
    @(posedge clk); #1;

    foreach (vals[i]) begin
      send(vals[i], 1'b0, a);
      wait_done(1'b0, dc);
      chk("latency_boundary", dc - a, 20);
    end

    // 507 with full held across the first ten SEND cycles
    mode = 3;
    send(507, 1'b0, a);
    slo = a + 14;
    shi = a + 23;
    for (int k = 0; k <= 23; k++) begin
      @(negedge clk);
      if (k >= 14) begin
        chk("stall_push", int'(push_a), 0);
        chk("stall_data", int'(data_a), 8'h30);
        chk("stall_busy", int'(busy_a), 1);
      end
    end
    wait_done(1'b0, dc);
    chk("stall_latency", dc - a, 30);
    mode = 0;

    // Extra requests and count changes mid-frame are ignored
    send(3210, 1'b0, a);
    while (cyc < a + 24) begin
      @(posedge clk); #1;
      send_a = (cyc == a + 5 || cyc == a + 16);
      cnt_in = 14'($urandom_range(0, 16383));
    end
    send_a = 1'b0;
    @(negedge clk);
    chk("ignore_busy_after", int'(busy_a), 0);
    chk("ignore_queue_empty", qa.size(), 0);
    @(posedge clk); #1;

    // Reset after the third byte abandons the frame
    send(8765, 1'b0, a);
    goto(a + 16);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_push", int'(push_a), 0);
    chk("rst_mid_busy", int'(busy_a), 0);
    chk("rst_mid_left", qa.size(), 3);
    qa.delete();
    sent_a--;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rst_no_done", int'(dn_a), 0);
      chk("rst_no_push", int'(push_a), 0);
    end
    @(posedge clk); #1;
    send(8765, 1'b0, a);
    wait_done(1'b0, dc);
    chk("rst_fresh_latency", dc - a, 20);

    // Random values under random and toggling backpressure
    mode = 1;
    for (int i = 0; i < 8; i++) begin
      send(int'($urandom_range(0, 16383)), 1'b0, a);
      wait_done(1'b0, dc);
    end
    mode = 2;
    for (int i = 0; i < 3; i++) begin
      send(int'($urandom_range(0, 16383)), 1'b0, a);
      wait_done(1'b0, dc);
    end
    mode = 0;

    // Digits-only instance
    send(42, 1'b1, a);
    wait_done(1'b1, dc);
    chk("noeol_latency", dc - a, 18);
    for (int i = 0; i < 3; i++) begin
      send(int'($urandom_range(0, 16383)), 1'b1, a);
      wait_done(1'b1, dc);
    end

    repeat (3) @(posedge clk);
    chk("frames_a", done_a, sent_a);
    chk("frames_b", done_b, sent_b);
    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/count_ascii_tx.md
Name: count_ascii_tx

Overview:
- Reads the 4-digit counter value and sends it to the UART TX FIFO as ASCII text: four decimal digits followed by CR LF.
- Sits between the counter and the TX FIFO push side. It is the outbound complement of the UART RX → FIFO → counter command path.
- Binary-to-BCD conversion is sequential (double-dabble, one bit per clock). Bytes are pushed one per clock whenever the FIFO is not full.

Parameters:
- COUNT_W, 14, width of i_count; must be ≥ $clog2(MAX_VAL+1).
- MAX_VAL, 9999, saturation limit; the latched count is clamped to this value.
- EOL_EN, 1, 1 = append 0x0D 0x0A after the digits (6 bytes per frame); 0 = digits only (4 bytes per frame).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- i_count  input  COUNT_W  counter value; sampled only on accepted request
- i_send  input  1  send request; single-cycle pulse or level
- i_fifo_full  input  1  TX FIFO full flag
- o_push  output  1  FIFO push strobe
- o_data  output  8  byte for FIFO; valid when o_push=1
- o_busy  output  1  high whenever not in IDLE
- o_done  output  1  one-cycle pulse after the last byte is pushed

Behaviour:
- Reset: rst is sampled on posedge clk and takes priority over everything.
  - State returns to IDLE; all internal registers are cleared.
  - o_push=0, o_data=8'h00, o_busy=0, o_done=0 from the cycle after the reset edge.
  - Reset mid-frame abandons the frame. No further push occurs and o_done is not pulsed.
- FSM states: IDLE, CONV, SEND, DONE.
- IDLE:
  - If i_send=1 at edge N, latch min(i_count, MAX_VAL) into the shift register, clear the BCD register and bit counter, and go to CONV.
  - i_send is ignored in every other state. There is no queuing.
- CONV: runs exactly COUNT_W cycles (14 by default). Each cycle:
  - First add 3 to every BCD nibble ≥5.
  - Then shift {bcd, bin} left by one.
  - After the COUNT_W-th shift, go to SEND with byte index 0.
- SEND:
  - o_push = 1 exactly when state==SEND and i_fifo_full==0. This is combinational from state and full, so the FIFO accepts on the same edge.
  - o_data = the byte at the current index: 0x30+thousands, 0x30+hundreds, 0x30+tens, 0x30+ones, then 0x0D, 0x0A.
  - Leading zeros are always sent (e.g. 42 → "0042").
  - The index advances only on an edge where o_push=1. While full=1, state and index hold, o_push=0, and o_data stays stable.
  - After pushing the last byte (index 5, or index 3 when EOL_EN=0), go to DONE.
- DONE: o_done=1 for exactly one cycle, then go to IDLE.
- Latency with i_send accepted at edge N:
  - CONV occupies cycles N+1 … N+14.
  - First push occurs in cycle N+15 if the FIFO is not full.
  - With no backpressure, the last push is in cycle N+20 and o_done is in N+21 (N+19 when EOL_EN=0).
- o_busy = (state != IDLE). It is therefore high from N+1 through the DONE cycle inclusive.
- A new request is accepted at the earliest on the edge ending the cycle after DONE.
- Boundaries:
  - i_count > MAX_VAL sends "9999".
  - i_count=0 sends "0000".
  - Full asserted continuously stalls SEND indefinitely, with no timeout.
  - Full toggling every cycle gives one byte per two cycles, with no byte lost or duplicated.
  - i_count changing during CONV or SEND has no effect on the frame.

Test Plan:
- Reset, then i_send pulse with i_count=1234 and full=0: pushes 0x31,0x32,0x33,0x34,0x0D,0x0A on consecutive cycles N+15…N+20; o_done at N+21; o_busy low at N+22.
- i_count=0, then i_count=9999, then i_count=16383: frames are "0000\r\n", "9999\r\n", and "9999\r\n" (clamped).
- i_count=507, with full held high cycles N+15…N+24 and low afterwards: no push while full; "0507\r\n" completes with exactly 6 pushes and o_data stable during the stall.
- i_send pulsed again during CONV and SEND, and i_count changed mid-frame: only one frame, carrying the originally latched value.
- rst asserted during SEND after 3 bytes: o_push=0 and o_busy=0 the next cycle; no o_done; the next i_send produces a complete fresh frame.
- EOL_EN=0 with i_count=42: exactly 4 pushes "0042"; o_done at N+19.
